// File: rtl/priv_1_12_trap_redirect_if.sv
// Handshake and CSR bundle between the trap/MRET sources, the CSR file, fetch and the redirect sequencer.
// The master side drives requests and CSR values; the slave side is the redirect sequencer.
interface priv_1_12_trap_redirect_if #(
    parameter int CNT_W = 16
);
    logic             intr;
    logic             mret;
    logic             pipe_clear;
    logic             redirect_ack;
    logic [29:0]      mtvec_base;
    logic [1:0]       mtvec_mode;
    logic             mcause_int;
    logic [30:0]      mcause_code;
    logic [31:0]      mepc;
    logic             insert_pc;
    logic [31:0]      priv_pc;
    logic             busy;
    logic [CNT_W-1:0] redirect_count;
    logic             drain_timeout;

    modport master (
        output intr, mret, pipe_clear, redirect_ack,
        output mtvec_base, mtvec_mode, mcause_int, mcause_code, mepc,
        input  insert_pc, priv_pc, busy, redirect_count, drain_timeout
    );

    modport slave (
        input  intr, mret, pipe_clear, redirect_ack,
        input  mtvec_base, mtvec_mode, mcause_int, mcause_code, mepc,
        output insert_pc, priv_pc, busy, redirect_count, drain_timeout
    );
endinterface

// File: rtl/priv_1_12_trap_redirect.sv
// Registered trap/MRET PC redirect: waits for a clear pipe, latches the target from
// mtvec/mcause/mepc, and holds insert_pc/priv_pc until fetch acknowledges.
module priv_1_12_trap_redirect #(
    parameter int CNT_W     = 16,
    parameter int DRAIN_MAX = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    priv_1_12_trap_redirect_if.slave      bus
);
    localparam int DW = $clog2(DRAIN_MAX + 1);

    typedef enum logic [1:0] {IDLE, DRAIN, ISSUE} state_t;
    typedef enum logic       {TRAP, RET}          kind_t;

    state_t           state_q, state_n;
    kind_t            kind_q, kind_n;
    logic             pend_q, pend_n;
    logic [DW-1:0]    drain_q, drain_n;
    logic             load_pc;
    logic             count_inc;
    logic             timeout_set;
    logic [31:0]      target;
    logic [31:0]      base_addr;
    logic             insert_pc_q;
    logic             busy_q;
    logic [31:0]      priv_pc_q;
    logic [CNT_W-1:0] count_q;
    logic             timeout_q;

    // Bits the target never uses (mcause_code[30], mepc[1:0]).
    logic unused_bits;
    assign unused_bits = ^{bus.mcause_code[30], bus.mepc[1:0]};

    // NOTE: every always_comb output gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_n   = state_q;
        kind_n    = kind_q;
        pend_n    = pend_q;
        drain_n   = drain_q;
        load_pc   = 1'b0;
        count_inc = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.intr) begin
                    kind_n  = TRAP;
                    state_n = DRAIN;
                end else if (bus.mret) begin
                    kind_n  = RET;
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.intr) kind_n = TRAP;
                if (bus.pipe_clear) begin
                    load_pc = 1'b1;
                    drain_n = '0;
                    state_n = ISSUE;
                end else if (drain_q != DW'(DRAIN_MAX)) begin
                    drain_n = drain_q + 1'b1;
                end
            end
            ISSUE: begin
                if (bus.intr) pend_n = 1'b1;
                if (bus.redirect_ack) begin
                    count_inc = 1'b1;
                    if (pend_q || bus.intr) begin
                        kind_n  = TRAP;
                        pend_n  = 1'b0;
                        state_n = DRAIN;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign timeout_set = (state_q == DRAIN) && (drain_n == DW'(DRAIN_MAX));

    // The effective kind this cycle lets a same-cycle intr upgrade an MRET target.
    always_comb begin
        base_addr = {bus.mtvec_base, 2'b00};
        target    = base_addr;
        if (kind_n == RET) begin
            target = {bus.mepc[31:2], 2'b00};
        end else if (bus.mtvec_mode == 2'd1 && bus.mcause_int) begin
            target = base_addr + {bus.mcause_code[29:0], 2'b00};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            kind_q      <= TRAP;
            pend_q      <= 1'b0;
            drain_q     <= '0;
            insert_pc_q <= 1'b0;
            busy_q      <= 1'b0;
            priv_pc_q   <= '0;
            count_q     <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_n;
            kind_q      <= kind_n;
            pend_q      <= pend_n;
            drain_q     <= drain_n;
            insert_pc_q <= (state_n == ISSUE);
            busy_q      <= (state_n != IDLE);
            if (load_pc) priv_pc_q <= target;
            if (count_inc && count_q != '1) count_q <= count_q + 1'b1;
            if (timeout_set) timeout_q <= 1'b1;
        end
    end

    assign bus.insert_pc      = insert_pc_q;
    assign bus.busy           = busy_q;
    assign bus.priv_pc        = priv_pc_q;
    assign bus.redirect_count = count_q;
    assign bus.drain_timeout  = timeout_q;
endmodule

// File: tb/tb_priv_1_12_trap_redirect.sv
// Directed bench for the trap/MRET redirect sequencer: target vectors from a table, then
// hand-written latency, hold, upgrade, pend, stall, reset and saturation sequences.
module tb_priv_1_12_trap_redirect;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    priv_1_12_trap_redirect_if #(.CNT_W(CNT_W)) bus ();
    priv_1_12_trap_redirect #(.CNT_W(CNT_W), .DRAIN_MAX(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // A 2-bit counter instance follows the same stimulus so saturation is reached quickly.
    priv_1_12_trap_redirect_if #(.CNT_W(2)) sbus ();
    priv_1_12_trap_redirect #(.CNT_W(2), .DRAIN_MAX(64)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (sbus)
    );
    assign sbus.intr         = bus.intr;
    assign sbus.mret         = bus.mret;
    assign sbus.pipe_clear   = bus.pipe_clear;
    assign sbus.redirect_ack = bus.redirect_ack;
    assign sbus.mtvec_base   = bus.mtvec_base;
    assign sbus.mtvec_mode   = bus.mtvec_mode;
    assign sbus.mcause_int   = bus.mcause_int;
    assign sbus.mcause_code  = bus.mcause_code;
    assign sbus.mepc         = bus.mepc;

    typedef struct {
        string       name;
        logic        intr;
        logic        mret;
        logic [1:0]  mode;
        logic [31:0] base;
        logic        cint;
        logic [30:0] code;
        logic [31:0] mepc;
        logic [31:0] exp_pc;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;
    int exp_count = 0;
    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.intr         = 1'b0;
        bus.mret         = 1'b0;
        bus.pipe_clear   = 1'b0;
        bus.redirect_ack = 1'b0;
    endtask

    task automatic set_csr(input logic [1:0] mode, input logic [31:0] base, input logic cint,
                           input logic [30:0] code, input logic [31:0] mepc);
        bus.mtvec_mode  = mode;
        bus.mtvec_base  = base[31:2];
        bus.mcause_int  = cint;
        bus.mcause_code = code;
        bus.mepc        = mepc;
    endtask

    task automatic run_vec(input vec_t v);
        set_csr(v.mode, v.base, v.cint, v.code, v.mepc);
        bus.intr = v.intr;
        bus.mret = v.mret;
        tick();
        clear_inputs();
        check({v.name, " drain busy"}, 64'(bus.busy), 64'd1);
        bus.pipe_clear = 1'b1;
        tick();
        bus.pipe_clear = 1'b0;
        check({v.name, " insert_pc"}, 64'(bus.insert_pc), 64'd1);
        check({v.name, " priv_pc"}, 64'(bus.priv_pc), 64'(v.exp_pc));
        bus.redirect_ack = 1'b1;
        tick();
        bus.redirect_ack = 1'b0;
        exp_count++;
        check({v.name, " idle"}, 64'({bus.insert_pc, bus.busy}), 64'd0);
        check({v.name, " count"}, 64'(bus.redirect_count), 64'(exp_count));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{"direct",     1'b1, 1'b0, 2'd0, 32'h2000_0000, 1'b0, 31'd0,          32'h0,         32'h2000_0000};
        vecs[1] = '{"vec_int",    1'b1, 1'b0, 2'd1, 32'h0000_0100, 1'b1, 31'd7,          32'h0,         32'h0000_011C};
        vecs[2] = '{"vec_exc",    1'b1, 1'b0, 2'd1, 32'h0000_0100, 1'b0, 31'd7,          32'h0,         32'h0000_0100};
        vecs[3] = '{"mode3",      1'b1, 1'b0, 2'd3, 32'h0000_0100, 1'b1, 31'd7,          32'h0,         32'h0000_0100};
        vecs[4] = '{"mret",       1'b0, 1'b1, 2'd0, 32'h0000_0100, 1'b0, 31'd0,          32'h8000_0013, 32'h8000_0010};
        vecs[5] = '{"intr_mret",  1'b1, 1'b1, 2'd0, 32'h0000_0400, 1'b0, 31'd0,          32'h8000_0013, 32'h0000_0400};
        vecs[6] = '{"vec_wrap",   1'b1, 1'b0, 2'd1, 32'hFFFF_FFF0, 1'b1, 31'd8,          32'h0,         32'h0000_0010};
        vecs[7] = '{"mode2",      1'b1, 1'b0, 2'd2, 32'h0000_0200, 1'b1, 31'd3,          32'h0,         32'h0000_0200};
        vecs[8] = '{"code_trunc", 1'b1, 1'b0, 2'd1, 32'h0000_1000, 1'b1, 31'h4000_0001, 32'h0,         32'h0000_1004};

        rst = 1'b1;
        clear_inputs();
        set_csr(2'd0, 32'h0, 1'b0, 31'd0, 32'h0);
        tick();
        tick();
        check("reset insert_pc", 64'(bus.insert_pc), 64'd0);
        check("reset priv_pc", 64'(bus.priv_pc), 64'd0);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset count", 64'(bus.redirect_count), 64'd0);
        check("reset timeout", 64'(bus.drain_timeout), 64'd0);
        rst = 1'b0;
        tick();

        // pipe_clear alone in IDLE must not start anything.
        bus.pipe_clear = 1'b1;
        tick();
        bus.pipe_clear = 1'b0;
        check("idle pipe_clear busy", 64'(bus.busy), 64'd0);

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Latency and hold: request N, clear N+1, insert N+2; priv_pc stays put while unacked.
        set_csr(2'd0, 32'h2000_0000, 1'b0, 31'd0, 32'h0);
        bus.intr = 1'b1;
        tick();
        bus.intr = 1'b0;
        check("lat insert N+1", 64'(bus.insert_pc), 64'd0);
        bus.pipe_clear = 1'b1;
        tick();
        bus.pipe_clear = 1'b0;
        check("lat insert N+2", 64'(bus.insert_pc), 64'd1);
        bus.mtvec_base = 30'h0000_0123;
        bus.mret = 1'b1;
        tick();
        bus.mret = 1'b0;
        check("hold insert", 64'(bus.insert_pc), 64'd1);
        check("hold priv_pc", 64'(bus.priv_pc), 64'h2000_0000);
        bus.redirect_ack = 1'b1;
        tick();
        bus.redirect_ack = 1'b0;
        exp_count++;
        check("hold idle busy", 64'(bus.busy), 64'd0);
        check("hold count", 64'(bus.redirect_count), 64'(exp_count));

        // Upgrade: MRET in flight, intr during DRAIN turns it into a trap.
        set_csr(2'd0, 32'h0000_0300, 1'b0, 31'd0, 32'h8000_0000);
        bus.mret = 1'b1;
        tick();
        bus.mret = 1'b0;
        bus.intr = 1'b1;
        tick();
        bus.intr = 1'b0;
        bus.pipe_clear = 1'b1;
        tick();
        bus.pipe_clear = 1'b0;
        check("upgrade priv_pc", 64'(bus.priv_pc), 64'h0000_0300);
        bus.redirect_ack = 1'b1;
        tick();
        bus.redirect_ack = 1'b0;
        exp_count++;

        // Pend: intr during ISSUE yields a second redirect after the ack.
        set_csr(2'd1, 32'h0000_0800, 1'b1, 31'd2, 32'h0);
        bus.intr = 1'b1;
        tick();
        bus.intr = 1'b0;
        bus.pipe_clear = 1'b1;
        tick();
        bus.pipe_clear = 1'b0;
        check("pend first priv_pc", 64'(bus.priv_pc), 64'h0000_0808);
        bus.intr = 1'b1;
        tick();
        bus.intr = 1'b0;
        bus.redirect_ack = 1'b1;
        tick();
        bus.redirect_ack = 1'b0;
        exp_count++;
        check("pend redrain", 64'({bus.busy, bus.insert_pc}), 64'b10);
        bus.mcause_code = 31'd5;
        bus.pipe_clear = 1'b1;
        tick();
        bus.pipe_clear = 1'b0;
        check("pend second priv_pc", 64'(bus.priv_pc), 64'h0000_0814);
        bus.redirect_ack = 1'b1;
        tick();
        bus.redirect_ack = 1'b0;
        exp_count++;
        check("pend idle", 64'(bus.busy), 64'd0);
        check("pend count", 64'(bus.redirect_count), 64'(exp_count));

        check("sat count", 64'(sbus.redirect_count), 64'd3);

        // Stall: timeout after 64 DRAIN cycles, sticky, redirect still completes.
        set_csr(2'd0, 32'h0000_0040, 1'b0, 31'd0, 32'h0);
        bus.intr = 1'b1;
        tick();
        bus.intr = 1'b0;
        for (int i = 0; i < 63; i++) tick();
        check("stall timeout at 63", 64'(bus.drain_timeout), 64'd0);
        tick();
        check("stall timeout at 64", 64'(bus.drain_timeout), 64'd1);
        for (int i = 0; i < 6; i++) tick();
        check("stall still waiting", 64'({bus.busy, bus.insert_pc}), 64'b10);
        bus.pipe_clear = 1'b1;
        tick();
        bus.pipe_clear = 1'b0;
        check("stall priv_pc", 64'(bus.priv_pc), 64'h0000_0040);
        bus.redirect_ack = 1'b1;
        tick();
        bus.redirect_ack = 1'b0;
        exp_count++;
        check("stall count", 64'(bus.redirect_count), 64'(exp_count));
        check("stall timeout sticky", 64'(bus.drain_timeout), 64'd1);

        // Asynchronous reset in ISSUE drops the redirect immediately.
        bus.intr = 1'b1;
        tick();
        bus.intr = 1'b0;
        bus.pipe_clear = 1'b1;
        tick();
        bus.pipe_clear = 1'b0;
        check("pre-reset insert", 64'(bus.insert_pc), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async rst insert_pc", 64'(bus.insert_pc), 64'd0);
        check("async rst priv_pc", 64'(bus.priv_pc), 64'd0);
        check("async rst count", 64'(bus.redirect_count), 64'd0);
        check("async rst timeout", 64'(bus.drain_timeout), 64'd0);
        #1;
        rst = 1'b0;
        tick();
        check("post reset busy", 64'(bus.busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
